// File: rtl/img_pkg.sv
// Shared types and UART frame constants for the image receive path.
package img_pkg;

    // Image-level receiver state; values are exported on the out_state debug port
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVING = 2'd1,
        DONE      = 2'd2
    } rx_state_t;

    // Bit-level UART deserialiser state
    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_t;

    // 8N1 framing
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, detects the start edge, samples each bit at
// its centre and reports either a good byte or a framing error for one cycle.
module uart_rx
    import img_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 50
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    logic        rx_meta, rx_s, rx_prev;
    uart_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shift, shift_n;
    logic        valid_n, err_n;

    // The shift register holds the finished byte in the cycle valid_o is high
    assign data_o = shift;

    // Synchroniser, edge history and all receiver state registers
    always_ff @(posedge clk) begin
        if (rst_in) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev     <= 1'b1;
            state       <= U_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rx_s        <= rx_meta;
            rx_prev     <= rx_s;
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_n;
            shift       <= shift_n;
            valid_o     <= valid_n;
            frame_err_o <= err_n;
        end
    end

    // Next-state logic: a half-bit wait recentres sampling on the start bit,
    // then each data and stop bit is sampled one full bit period later
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            U_IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                if (rx_prev && !rx_s) begin
                    state_n = U_START;
                end
            end
            U_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = rx_s ? U_IDLE : U_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            U_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[7:1]};
                    if (bit_idx == LAST_BIT) begin
                        state_n = U_STOP;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            U_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_n   = '0;
                    valid_n = rx_s;
                    err_n   = !rx_s;
                    state_n = U_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = U_IDLE;
        endcase
    end

endmodule

// File: rtl/recv_img.sv
// Image receiver: writes UART bytes into consecutive BRAM addresses and pulses
// img_ready once the whole image has been stored; aborts on a mid-image stall.
module recv_img
    import img_pkg::*;
#(
    parameter int BRAM_LENGTH     = 64 * 64,
    parameter int BIT_DEPTH       = 8,
    parameter int CLOCKS_PER_BAUD = 50,
    parameter int TIMEOUT_CYCLES  = 2 ** 20
) (
    input  logic                           clk,
    input  logic                           rst_in,
    input  logic                           rx,
    input  logic                           enable_in,
    output logic                           we,
    output logic [$clog2(BRAM_LENGTH)-1:0] address,
    output logic [BIT_DEPTH-1:0]           data_out,
    output logic                           img_ready,
    output logic                           busy,
    output logic                           rx_error,
    output logic [1:0]                     out_state
);

    localparam int ADDR_W = $clog2(BRAM_LENGTH);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BRAM_LENGTH - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    logic [7:0]          rx_data;
    logic                rx_valid, rx_frame_err;
    rx_state_t           state, state_n;
    logic [ADDR_W-1:0]   address_n;
    logic                we_n, err_n;
    logic [BIT_DEPTH-1:0] data_n;
    logic                pending, pending_n;
    logic [7:0]          pending_data, pending_data_n;
    logic [TO_W-1:0]     tcnt, tcnt_n;
    logic                byte_valid;
    logic [7:0]          byte_data;

    uart_rx #(.CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)) u_uart_rx (
        .clk         (clk),
        .rst_in      (rst_in),
        .rx          (rx),
        .data_o      (rx_data),
        .valid_o     (rx_valid),
        .frame_err_o (rx_frame_err)
    );

    // A byte parked during DONE is replayed as if it had just arrived
    assign byte_valid = rx_valid | pending;
    assign byte_data  = pending ? pending_data : rx_data;

    assign busy      = (state == RECEIVING);
    assign img_ready = (state == DONE);
    assign out_state = state;

    // Registers for FSM state, write port, parked byte and stall counter
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state        <= IDLE;
            address      <= '0;
            we           <= 1'b0;
            data_out     <= '0;
            rx_error     <= 1'b0;
            pending      <= 1'b0;
            pending_data <= '0;
            tcnt         <= '0;
        end else begin
            state        <= state_n;
            address      <= address_n;
            we           <= we_n;
            data_out     <= data_n;
            rx_error     <= err_n;
            pending      <= pending_n;
            pending_data <= pending_data_n;
            tcnt         <= tcnt_n;
        end
    end

    // Next-state logic: the address advances the cycle after each write, and a
    // byte landing on the stall deadline counts as activity rather than a timeout
    always_comb begin
        state_n        = state;
        address_n      = address;
        we_n           = 1'b0;
        data_n         = data_out;
        err_n          = rx_frame_err;
        pending_n      = 1'b0;
        pending_data_n = pending_data;
        tcnt_n         = tcnt;
        case (state)
            IDLE: begin
                tcnt_n = '0;
                if (byte_valid && enable_in) begin
                    we_n    = 1'b1;
                    data_n  = byte_data[BIT_DEPTH-1:0];
                    state_n = RECEIVING;
                end
            end
            RECEIVING: begin
                if (we) begin
                    if (address == LAST_ADDR) begin
                        address_n = '0;
                        state_n   = DONE;
                    end else begin
                        address_n = address + 1'b1;
                    end
                end
                if (rx_valid) begin
                    tcnt_n = '0;
                    if (enable_in) begin
                        we_n   = 1'b1;
                        data_n = rx_data[BIT_DEPTH-1:0];
                    end
                end else if (tcnt == TO_LAST) begin
                    err_n     = 1'b1;
                    address_n = '0;
                    tcnt_n    = '0;
                    state_n   = IDLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            DONE: begin
                tcnt_n  = '0;
                state_n = IDLE;
                if (rx_valid) begin
                    pending_n      = 1'b1;
                    pending_data_n = rx_data;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_recv_img.sv
// Directed bench for recv_img with a 16-pixel image and a short stall timeout.
module tb_recv_img;

    localparam int CPB     = 50;
    localparam int BLEN    = 16;
    localparam int TIMEOUT = 2000;
    localparam int GAP     = 10;

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic       rx = 1'b1;
    logic       enable_in = 1'b1;
    logic       we;
    logic [3:0] address;
    logic [7:0] data_out;
    logic       img_ready;
    logic       busy;
    logic       rx_error;
    logic [1:0] out_state;

    int assert_count = 0;
    int fail_count   = 0;

    int         wr_count    = 0;
    int         ready_count = 0;
    int         err_count   = 0;
    logic [3:0] log_addr [0:255];
    logic [7:0] log_data [0:255];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       en;
        int         exp_we;
        int         exp_addr;
        int         exp_ready;
        int         exp_err;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[$];

    recv_img #(
        .BRAM_LENGTH     (BLEN),
        .BIT_DEPTH       (8),
        .CLOCKS_PER_BAUD (CPB),
        .TIMEOUT_CYCLES  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .rx        (rx),
        .enable_in (enable_in),
        .we        (we),
        .address   (address),
        .data_out  (data_out),
        .img_ready (img_ready),
        .busy      (busy),
        .rx_error  (rx_error),
        .out_state (out_state)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Monitor on the falling edge: log every write and count the pulse outputs
    always @(negedge clk) begin
        if (we) begin
            if (wr_count < 256) begin
                log_addr[wr_count] = address;
                log_data[wr_count] = data_out;
            end
            wr_count++;
        end
        if (img_ready) ready_count++;
        if (rx_error)  err_count++;
    end

    // Safety net so the run can never hang
    initial begin
        #(2_000_000);
        $display("[TB] FAIL watchdog: simulation time limit reached, required end of test before it");
        $fatal(1, "[TB] watchdog");
    end

    // One comparison: counts it and reports a mismatch
    task automatic checkOutput(input string name, input int actual, input int expected);
        assert_count++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Serialise one 8N1 frame, LSB first; called and returns on a falling edge
    task automatic sendFrame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    // Drive one vector: set enable, send the frame, then leave the line idle
    task automatic applyStimulus(input vec_t v);
        enable_in = v.en;
        sendFrame(v.data, v.stop);
        repeat (GAP) @(negedge clk);
    endtask

    // Apply one vector and compare what it caused with what the vector expects
    task automatic runVec(input vec_t v, input string tag);
        int wc, rc, ec;
        wc = wr_count;
        rc = ready_count;
        ec = err_count;
        applyStimulus(v);
        checkOutput({tag, " writes"}, wr_count - wc, v.exp_we);
        if (v.exp_we == 1 && wr_count > wc) begin
            checkOutput({tag, " addr"}, int'(log_addr[wc]), v.exp_addr);
            checkOutput({tag, " data"}, int'(log_data[wc]), int'(v.data));
        end
        checkOutput({tag, " img_ready"}, ready_count - rc, v.exp_ready);
        checkOutput({tag, " rx_error"}, err_count - ec, v.exp_err);
        checkOutput({tag, " busy"}, int'(busy), int'(v.exp_busy));
    endtask

    function automatic vec_t mkVec(input logic [7:0] d, input logic stop, input logic en,
                                   input int w, input int a, input int r, input int e,
                                   input logic b);
        vec_t v;
        v.data = d; v.stop = stop; v.en = en;
        v.exp_we = w; v.exp_addr = a; v.exp_ready = r; v.exp_err = e; v.exp_busy = b;
        return v;
    endfunction

    // Send one full, error-free image of 16 bytes starting from value base
    task automatic sendImage(input logic [7:0] base, input string tag);
        for (int k = 0; k < BLEN; k++) begin
            runVec(mkVec(base + 8'(k), 1'b1, 1'b1, 1, k, (k == BLEN - 1) ? 1 : 0, 0,
                         (k != BLEN - 1)), tag);
        end
    endtask

    // Main sequence: table vectors first, then the multi-cycle corner cases
    initial begin
        int wc, rc, ec;

        // Image 1: bytes 0x00..0x0F fill addresses 0..15
        for (int k = 0; k < BLEN; k++)
            tbl.push_back(mkVec(8'(k), 1'b1, 1'b1, 1, k, (k == BLEN - 1) ? 1 : 0, 0,
                                (k != BLEN - 1)));
        // Image 2: dropped bytes while disabled, then a framing error at address 5
        tbl.push_back(mkVec(8'h10, 1'b1, 1'b1, 1, 0, 0, 0, 1'b1));
        tbl.push_back(mkVec(8'h11, 1'b1, 1'b1, 1, 1, 0, 0, 1'b1));
        tbl.push_back(mkVec(8'h12, 1'b1, 1'b1, 1, 2, 0, 0, 1'b1));
        tbl.push_back(mkVec(8'h55, 1'b1, 1'b0, 0, 0, 0, 0, 1'b1));
        tbl.push_back(mkVec(8'h66, 1'b1, 1'b0, 0, 0, 0, 0, 1'b1));
        tbl.push_back(mkVec(8'h13, 1'b1, 1'b1, 1, 3, 0, 0, 1'b1));
        tbl.push_back(mkVec(8'h14, 1'b1, 1'b1, 1, 4, 0, 0, 1'b1));
        tbl.push_back(mkVec(8'hA5, 1'b0, 1'b1, 0, 0, 0, 1, 1'b1));
        tbl.push_back(mkVec(8'h3C, 1'b1, 1'b1, 1, 5, 0, 0, 1'b1));
        for (int k = 0; k < 10; k++)
            tbl.push_back(mkVec(8'h40 + 8'(k), 1'b1, 1'b1, 1, 6 + k, (k == 9) ? 1 : 0, 0,
                                (k != 9)));

        // Reset state
        repeat (4) @(negedge clk);
        checkOutput("reset outputs", int'({we, address, data_out, img_ready, busy, rx_error, out_state}), 0);
        rst_in = 1'b0;
        repeat (GAP) @(negedge clk);
        checkOutput("idle outputs", int'({we, address, data_out, img_ready, busy, rx_error, out_state}), 0);

        for (int i = 0; i < tbl.size(); i++) runVec(tbl[i], $sformatf("vec%0d", i));
        checkOutput("address wrap", int'(address), 0);
        checkOutput("state after image", int'(out_state), 0);

        // Stall mid-image: six bytes then silence until the timeout aborts
        for (int k = 0; k < 6; k++)
            runVec(mkVec(8'h70 + 8'(k), 1'b1, 1'b1, 1, k, 0, 0, 1'b1), "pre-timeout");
        wc = wr_count; ec = err_count;
        repeat (TIMEOUT + 100) @(negedge clk);
        checkOutput("timeout rx_error", err_count - ec, 1);
        checkOutput("timeout writes", wr_count - wc, 0);
        checkOutput("timeout busy", int'(busy), 0);
        checkOutput("timeout state", int'(out_state), 0);
        checkOutput("timeout address", int'(address), 0);
        sendImage(8'h90, "post-timeout");

        // Reset after the ninth byte discards the partial image
        for (int k = 0; k < 9; k++)
            runVec(mkVec(8'h81 + 8'(k), 1'b1, 1'b1, 1, k, 0, 0, 1'b1), "pre-reset");
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        checkOutput("mid-image reset outputs", int'({we, address, data_out, img_ready, busy, rx_error, out_state}), 0);
        repeat (GAP) @(negedge clk);
        sendImage(8'hC0, "post-reset");

        // Two images sent back to back with no idle time between frames
        wc = wr_count; rc = ready_count; ec = err_count;
        enable_in = 1'b1;
        for (int k = 0; k < 2 * BLEN; k++) sendFrame(8'hE0 ^ 8'(k), 1'b1);
        repeat (GAP) @(negedge clk);
        checkOutput("b2b writes", wr_count - wc, 2 * BLEN);
        checkOutput("b2b img_ready", ready_count - rc, 2);
        checkOutput("b2b rx_error", err_count - ec, 0);
        for (int k = 0; k < 2 * BLEN && wc + k < 256; k++) begin
            checkOutput($sformatf("b2b addr%0d", k), int'(log_addr[wc + k]), k % BLEN);
            checkOutput($sformatf("b2b data%0d", k), int'(log_data[wc + k]), int'(8'hE0 ^ 8'(k)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
